// File: rtl/serial_frame_gen_pkg.sv
// serial_frame_gen_pkg: shared FSM state encoding, field widths and line levels
// for the serial frame generator.
package serial_frame_gen_pkg;

    typedef enum logic [2:0] {IDLE, START, PORT, NUM, DATA} state_t;

    localparam int   PORT_W    = 2;
    localparam int   NUM_W     = 4;
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/serial_frame_gen_frame_shr.sv
// serial_frame_gen_frame_shr: loadable left-shift register holding
// {start bit, port, num, data aligned to MSB}; its MSB is the serial line.
//   clk, rst  : clock, synchronous active-low reset (register goes to idle level)
//   load      : capture a new frame
//   shift     : advance one bit, filling with the idle level
//   port/num/data : frame fields captured on load
//   msb       : current serial bit
module serial_frame_gen_frame_shr
    import serial_frame_gen_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [PORT_W-1:0] port,
    input  logic [NUM_W-1:0]  num,
    input  logic [DATA_W-1:0] data,
    output logic              msb
);

    localparam int W = 1 + PORT_W + NUM_W + DATA_W;

    logic [W-1:0]      q;
    logic [DATA_W-1:0] aligned;
    int                sh;

    // data[num-1:0] moved to the top; the vacated low bits are filled with the
    // idle level so the line reads idle as soon as the last data bit leaves.
    assign sh      = DATA_W - int'(num);
    assign aligned = (data << sh) | ~({DATA_W{1'b1}} << sh);
    assign msb     = q[W-1];

    always_ff @(posedge clk) begin
        if (!rst)
            q <= {W{IDLE_LVL}};
        else if (load)
            q <= {START_LVL, port, num, aligned};
        else if (shift)
            q <= {q[W-2:0], IDLE_LVL};
    end

endmodule

// File: rtl/serial_frame_gen.sv
// serial_frame_gen: emits start bit, 2-bit port, 4-bit count and count data bits
// on a single serial line, one bit per clkEn period.
//   clk, rst   : clock, synchronous active-low reset
//   clkEn      : bit-rate enable
//   start      : frame request, accepted when ready & start & clkEn
//   port/num/data : frame contents, captured on acceptance
//   ready/busy : idle / frame in progress
//   done       : one-clock pulse when the frame completes
//   SerOut     : serial line, idle high
module serial_frame_gen
    import serial_frame_gen_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              start,
    input  logic [1:0]        port,
    input  logic [3:0]        num,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              SerOut
);

    state_t           state, state_n;
    logic [NUM_W-1:0] cnt, cnt_n, num_q;
    logic             done_n, load, shift;

    assign ready = (state == IDLE);
    assign busy  = ~ready;
    assign load  = ready & start & clkEn;
    assign shift = busy & clkEn;

    // cnt holds bits remaining in the current field minus one; a field ends
    // on the enabled edge where it reads zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (clkEn) begin
            if (state != IDLE && cnt != '0)
                cnt_n = cnt - 1'b1;
            else
                case (state)
                    IDLE:    if (start) begin state_n = START; cnt_n = '0; end
                    START:   begin state_n = PORT; cnt_n = NUM_W'(PORT_W - 1); end
                    PORT:    begin state_n = NUM;  cnt_n = NUM_W'(NUM_W - 1); end
                    NUM:     begin state_n = (num_q == '0) ? IDLE : DATA; cnt_n = num_q - 1'b1; end
                    default: state_n = IDLE;
                endcase
        end
        done_n = (state != IDLE) && (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            num_q <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            num_q <= load ? num : num_q;
            done  <= done_n;
        end
    end

    serial_frame_gen_frame_shr #(.DATA_W(DATA_W)) u_frame_shr (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .port  (port),
        .num   (num),
        .data  (data),
        .msb   (SerOut)
    );

endmodule

// File: tb/tb_serial_frame_gen.sv
// tb_serial_frame_gen: table-driven and randomized checks against a bit-queue model.
module tb_serial_frame_gen;

    logic        clk = 1'b0;
    logic        rst, clkEn, start, ready, busy, done, SerOut;
    logic [1:0]  port;
    logic [3:0]  num;
    logic [15:0] data;

    int vectors = 0, miscompares = 0;
    int en_div = 1;
    int cyc = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    serial_frame_gen #(.DATA_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .clkEn  (clkEn),
        .start  (start),
        .port   (port),
        .num    (num),
        .data   (data),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .SerOut (SerOut)
    );

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  num;
        logic [15:0] data;
        int          div;
        logic [21:0] seq;
        int          len;
    } vec_t;

    vec_t tab[5];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // clkEn pattern: div>0 -> every div-th clock, 0 -> held low, <0 -> random
    initial forever begin
        @(negedge clk);
        if (en_div > 0) clkEn = (cyc % en_div) == 0;
        else if (en_div == 0) clkEn = 1'b0;
        else clkEn = 1'($urandom_range(0, 1));
        cyc++;
    end

    // Reference model: the frame is a queue of line bits still to be sent.
    bit          m_q[$];
    bit          m_done, m_acc;
    logic        cap[$];
    logic        s_rst, s_en, s_start;
    logic [1:0]  s_port;
    logic [3:0]  s_num;
    logic [15:0] s_data;

    initial forever begin
        @(posedge clk);
        s_rst = rst; s_en = clkEn; s_start = start;
        s_port = port; s_num = num; s_data = data;
        m_acc = 0; m_done = 0;
        if (!s_rst) m_q.delete();
        else if (s_en) begin
            if (m_q.size() != 0) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1;
            end else if (s_start) begin
                m_acc = 1;
                m_q.push_back(1'b0);
                for (int i = 1; i >= 0; i--) m_q.push_back(s_port[i]);
                for (int i = 3; i >= 0; i--) m_q.push_back(s_num[i]);
                for (int i = int'(s_num) - 1; i >= 0; i--) m_q.push_back(s_data[i]);
            end
        end
        #1;
        check("SerOut", SerOut, (m_q.size() != 0) ? m_q[0] : 1'b1);
        check("ready", ready, m_q.size() == 0);
        check("busy", busy, m_q.size() != 0);
        check("done", done, m_done);
        if (s_rst && s_en && m_q.size() != 0) cap.push_back(SerOut);
        if (done === 1'b1) done_cnt++;
    end

    task automatic send_frame(input logic [1:0] p, input logic [3:0] n, input logic [15:0] d, input bit scramble);
        bit ok;
        @(negedge clk);
        port = p; num = n; data = d; start = 1'b1;
        cap.delete();
        ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin @(posedge clk); #2; ok = m_acc && busy; end
        if (!ok) begin miscompares++; $display("FAIL accept_timeout: busy %b after 400 cycles", busy); end
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin port = ~p; num = ~n; data = ~d; end
        ok = 0;
        for (int k = 0; k < 2000 && !ok; k++) begin @(posedge clk); #2; ok = done; end
        if (!ok) begin miscompares++; $display("FAIL done_timeout: done %b after 2000 cycles", done); end
    endtask

    task automatic check_tab(input int i);
        check("cap_len", cap.size(), tab[i].len);
        for (int j = 0; j < tab[i].len && j < cap.size(); j++)
            check("cap_bit", cap[j], tab[i].seq[tab[i].len-1-j]);
    endtask

    initial begin
        int dc, r;
        logic [3:0] rn;
        rst = 1'b0; clkEn = 1'b0; start = 1'b0; port = '0; num = '0; data = '0;
        tab[0] = '{2'd2, 4'd3,  16'b101,   1, 22'b0_10_0011_101, 10};
        tab[1] = '{2'd3, 4'd0,  16'hFFFF,  1, 22'b0_11_0000, 7};
        tab[2] = '{2'd1, 4'd15, 16'h5A5A,  4, 22'b0_01_1111_101101001011010, 22};
        tab[3] = '{2'd0, 4'd1,  16'h0001,  2, 22'b0_00_0001_1, 8};
        tab[4] = '{2'd1, 4'd8,  16'hFFC3,  1, 22'b0_01_1000_11000011, 15};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset_ready", ready, 1'b1);
        check("reset_line", SerOut, 1'b1);

        for (int i = 0; i < 5; i++) begin
            en_div = tab[i].div;
            send_frame(tab[i].port, tab[i].num, tab[i].data, 1'b0);
            check_tab(i);
            repeat (2) @(negedge clk);
        end

        // inputs scrambled after acceptance must not affect the frame
        en_div = 1;
        send_frame(tab[4].port, tab[4].num, tab[4].data, 1'b1);
        check_tab(4);

        // request with clkEn low is never accepted
        en_div = 0;
        repeat (2) @(negedge clk);
        port = 2'd1; num = 4'd2; start = 1'b1;
        repeat (6) @(negedge clk);
        check("no_accept_busy", busy, 1'b0);
        start = 1'b0;
        en_div = 1;
        repeat (2) @(negedge clk);

        // reset during DATA: no done, line idle, next frame normal
        port = 2'd1; num = 4'd10; data = 16'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_rst", busy, 1'b1);
        dc = done_cnt;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_line", SerOut, 1'b1);
        check("rst_ready", ready, 1'b1);
        repeat (12) @(negedge clk);
        check("rst_no_done", done_cnt, dc);
        send_frame(tab[0].port, tab[0].num, tab[0].data, 1'b0);
        check_tab(0);

        // start held: 8-bit frames separated by one idle bit -> 5 in 45 edges
        @(negedge clk);
        port = 2'd1; num = 4'd1; data = 16'($urandom); start = 1'b1;
        dc = done_cnt;
        repeat (45) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("held_dones", done_cnt - dc, 5);

        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 3);
            en_div = (r == 0) ? -1 : r;
            rn = 4'($urandom);
            send_frame(2'($urandom), rn, 16'($urandom), 1'($urandom));
            check("rnd_len", cap.size(), 7 + int'(rn));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
